// File: rtl/decimate_avg_if.sv
// Sample stream bundle for decimate_avg: the input stream (x_*) and the
// decimated output stream (y_*). Each stream uses a valid/ready handshake.
interface decimate_avg_if #(
    parameter int W   = 16,
    parameter int NCH = 1
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic                x_valid;
    logic                x_ready;
    logic signed [W-1:0] x_data;
    logic                y_valid;
    logic                y_ready;
    logic signed [W-1:0] y_data;
    logic [CW-1:0]       y_chan;

    modport slave (
        input  x_valid, x_data, y_ready,
        output x_ready, y_valid, y_data, y_chan
    );

    modport master (
        output x_valid, x_data, y_ready,
        input  x_ready, y_valid, y_data, y_chan
    );
endinterface

// File: rtl/decimate_avg.sv
// Multi-channel decimator for the pitch path: keeps one sample per group of
// 2^L per channel (pick), or emits the truncated boxcar mean of the group (average).
module decimate_avg #(
    parameter int W        = 16,
    parameter int NCH      = 1,
    parameter int MAX_LOG2 = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [$clog2(MAX_LOG2+1)-1:0]   log2_factor,
    input  logic                            mode,
    decimate_avg_if.slave                   bus
);
    localparam int LW   = $clog2(MAX_LOG2 + 1);
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW   = MAX_LOG2;
    localparam int AW   = W + MAX_LOG2;
    localparam int NACC = 1 << CW;

    logic [CW-1:0]        chan_q;
    logic [PW-1:0]        phase_q;
    logic [LW-1:0]        l_q;
    logic                 mode_q;
    logic signed [AW-1:0] acc [NACC];

    logic                 hs_p0;
    logic                 grp_start_p0;
    logic [LW-1:0]        l_p0;
    logic                 mode_p0;
    logic signed [AW-1:0] x_ext_p0;
    logic signed [AW-1:0] sum_p0;
    logic                 last_p0;
    logic                 emit_p0;
    logic signed [W-1:0]  y_next_p0;

    logic                 vld_p1;
    logic signed [W-1:0]  y_data_p1;
    logic [CW-1:0]        y_chan_p1;

    function automatic logic [LW-1:0] clamp_l(input logic [LW-1:0] l);
        if (l > LW'(MAX_LOG2)) begin
            return LW'(MAX_LOG2);
        end
        return l;
    endfunction

    function automatic logic [PW-1:0] last_phase(input logic [LW-1:0] l);
        return PW'((32'd1 << l) - 32'd1);
    endfunction

    // Arithmetic shift floors toward -inf; the group mean always fits in W bits.
    function automatic logic signed [W-1:0] avg_trunc(input logic signed [AW-1:0] s,
                                                      input logic [LW-1:0]        l);
        logic signed [AW-1:0] t;
        t = s >>> l;
        return t[W-1:0];
    endfunction

    assign bus.x_ready = !vld_p1 || bus.y_ready;

    // Stage 0: handshake decode, group config selection and accumulation.
    always_comb begin
        hs_p0        = bus.x_valid && bus.x_ready;
        grp_start_p0 = (chan_q == '0) && (phase_q == '0);
        l_p0         = grp_start_p0 ? clamp_l(log2_factor) : l_q;
        mode_p0      = grp_start_p0 ? mode : mode_q;
        x_ext_p0     = bus.x_data;
        sum_p0       = (phase_q == '0) ? x_ext_p0 : acc[chan_q] + x_ext_p0;
        last_p0      = (phase_q == last_phase(l_p0));
        emit_p0      = hs_p0 && (mode_p0 ? last_p0 : (phase_q == '0));
        y_next_p0    = mode_p0 ? avg_trunc(sum_p0, l_p0) : bus.x_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chan_q  <= '0;
            phase_q <= '0;
            l_q     <= '0;
            mode_q  <= 1'b0;
        end else if (hs_p0) begin
            l_q    <= l_p0;
            mode_q <= mode_p0;
            if (chan_q == CW'(NCH - 1)) begin
                chan_q  <= '0;
                phase_q <= last_p0 ? '0 : phase_q + 1'b1;
            end else begin
                chan_q <= chan_q + 1'b1;
            end
        end
    end

    // Phase 0 overwrites the accumulator, so it needs no reset.
    always_ff @(posedge clk) begin
        if (hs_p0) begin
            acc[chan_q] <= sum_p0;
        end
    end

    // Stage 1: single-slot output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            y_data_p1 <= '0;
            y_chan_p1 <= '0;
        end else if (emit_p0) begin
            vld_p1    <= 1'b1;
            y_data_p1 <= y_next_p0;
            y_chan_p1 <= chan_q;
        end else if (bus.y_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign bus.y_valid = vld_p1;
    assign bus.y_data  = y_data_p1;
    assign bus.y_chan  = y_chan_p1;
endmodule
